// File: rtl/fetch_stage.sv
// IF stage + IF/ID register: owns the PC, fetches over a variable-latency req/ack bus.
// Latency: a word acked in cycle N is on the IF/ID outputs in cycle N+1.
// Backpressure: hold (IFIDStall | ~PCWrite) parks an arriving word in a 1-entry buffer; slow memory yields bubbles.
// Optional: FETCH_PERF_CNT_EN enables the fetch/bubble performance counters.
module fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        PCWrite_i,
    input  logic        IFIDStall_i,
    input  logic        IFIDFlush_i,
    input  logic [31:0] branch_target_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_ack_i,
    input  logic [31:0] imem_rdata_i,
    output logic [31:0] pc_IFID_o,
    output logic [31:0] instr_IFID_o,
    output logic        valid_IFID_o,
    output logic [31:0] fetch_cnt_o,
    output logic [31:0] bubble_cnt_o
);

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_HOLD = 2'd1,
        S_DROP = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] drop_addr_q, drop_addr_d;
    logic [31:0] buf_pc_q, buf_pc_d;
    logic [31:0] buf_instr_q, buf_instr_d;
    logic [31:0] ifid_pc_q, ifid_pc_d;
    logic [31:0] ifid_instr_q, ifid_instr_d;
    logic        ifid_valid_q, ifid_valid_d;
    logic        hold;
    logic        ack;

    assign hold = IFIDStall_i | ~PCWrite_i;

    // The request is killed combinationally while reset is asserted so an
    // in-flight transaction is abandoned immediately.
    assign imem_req_o  = rst_i & (state_q != S_HOLD);
    assign imem_addr_o = (state_q == S_DROP) ? drop_addr_q : pc_q;
    assign ack         = imem_ack_i & imem_req_o;

    assign pc_IFID_o    = ifid_pc_q;
    assign instr_IFID_o = ifid_instr_q;
    assign valid_IFID_o = ifid_valid_q;

    // Next-state: flush beats hold, hold beats draining the buffer, then new data, else bubble.
    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        drop_addr_d  = drop_addr_q;
        buf_pc_d     = buf_pc_q;
        buf_instr_d  = buf_instr_q;
        ifid_pc_d    = ifid_pc_q;
        ifid_instr_d = ifid_instr_q;
        ifid_valid_d = ifid_valid_q;
        if (IFIDFlush_i) begin
            ifid_valid_d = 1'b0;
            ifid_instr_d = NOP_INSTR;
            pc_d         = branch_target_i;
            buf_pc_d     = '0;
            buf_instr_d  = NOP_INSTR;
            case (state_q)
                S_REQ: begin
                    // Request already on the bus cannot be withdrawn: remember
                    // its address and swallow the eventual response.
                    if (!ack) begin
                        drop_addr_d = pc_q;
                        state_d     = S_DROP;
                    end
                end
                S_DROP: begin
                    if (ack) state_d = S_REQ;
                end
                default: state_d = S_REQ;
            endcase
        end else if (hold) begin
            if (state_q == S_REQ && ack) begin
                buf_pc_d    = pc_q;
                buf_instr_d = imem_rdata_i;
                pc_d        = pc_q + 32'd4;
                state_d     = S_HOLD;
            end else if (state_q == S_DROP && ack) begin
                state_d = S_REQ;
            end
        end else if (state_q == S_HOLD) begin
            ifid_pc_d    = buf_pc_q;
            ifid_instr_d = buf_instr_q;
            ifid_valid_d = 1'b1;
            state_d      = S_REQ;
        end else if (state_q == S_REQ && ack) begin
            ifid_pc_d    = pc_q;
            ifid_instr_d = imem_rdata_i;
            ifid_valid_d = 1'b1;
            pc_d         = pc_q + 32'd4;
        end else begin
            ifid_pc_d    = pc_q;
            ifid_instr_d = NOP_INSTR;
            ifid_valid_d = 1'b0;
            if (state_q == S_DROP && ack) state_d = S_REQ;
        end
    end

    // State, PC, hold buffer and IF/ID register.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q      <= S_REQ;
            pc_q         <= RESET_PC;
            drop_addr_q  <= '0;
            buf_pc_q     <= '0;
            buf_instr_q  <= NOP_INSTR;
            ifid_pc_q    <= '0;
            ifid_instr_q <= NOP_INSTR;
            ifid_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            drop_addr_q  <= drop_addr_d;
            buf_pc_q     <= buf_pc_d;
            buf_instr_q  <= buf_instr_d;
            ifid_pc_q    <= ifid_pc_d;
            ifid_instr_q <= ifid_instr_d;
            ifid_valid_q <= ifid_valid_d;
        end
    end

`ifdef FETCH_PERF_CNT_EN
    logic        fetch_inc;
    logic        bubble_inc;
    logic [31:0] fetch_cnt_q;
    logic [31:0] bubble_cnt_q;

    assign fetch_inc  = ~IFIDFlush_i & ~hold &
                        ((state_q == S_HOLD) | ((state_q == S_REQ) & ack));
    assign bubble_inc = ~IFIDFlush_i & ~hold & ~fetch_inc;

    // Free-running wrap-around event counters.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            fetch_cnt_q  <= '0;
            bubble_cnt_q <= '0;
        end else begin
            if (fetch_inc)  fetch_cnt_q  <= fetch_cnt_q + 32'd1;
            if (bubble_inc) bubble_cnt_q <= bubble_cnt_q + 32'd1;
        end
    end

    assign fetch_cnt_o  = fetch_cnt_q;
    assign bubble_cnt_o = bubble_cnt_q;
`else
    assign fetch_cnt_o  = '0;
    assign bubble_cnt_o = '0;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Randomized bench for fetch_stage against a transaction-level reference model.
// Memory model answers requests after a random latency; hazards are random or directed.
// All outputs are sampled 1 ns after the falling edge.
module tb_fetch_stage;

    localparam logic [31:0] RESET_PC  = 32'h0000_0000;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    logic        clk_i;
    logic        rst_i;
    logic        PCWrite_i;
    logic        IFIDStall_i;
    logic        IFIDFlush_i;
    logic [31:0] branch_target_i;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_ack_i;
    logic [31:0] imem_rdata_i;
    logic [31:0] pc_IFID_o;
    logic [31:0] instr_IFID_o;
    logic        valid_IFID_o;
    logic [31:0] fetch_cnt_o;
    logic [31:0] bubble_cnt_o;

    fetch_stage #(.RESET_PC(RESET_PC), .NOP_INSTR(NOP_INSTR)) dut (
        .clk_i           (clk_i),
        .rst_i           (rst_i),
        .PCWrite_i       (PCWrite_i),
        .IFIDStall_i     (IFIDStall_i),
        .IFIDFlush_i     (IFIDFlush_i),
        .branch_target_i (branch_target_i),
        .imem_req_o      (imem_req_o),
        .imem_addr_o     (imem_addr_o),
        .imem_ack_i      (imem_ack_i),
        .imem_rdata_i    (imem_rdata_i),
        .pc_IFID_o       (pc_IFID_o),
        .instr_IFID_o    (instr_IFID_o),
        .valid_IFID_o    (valid_IFID_o),
        .fetch_cnt_o     (fetch_cnt_o),
        .bubble_cnt_o    (bubble_cnt_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    int n_chk  = 0;
    int n_fail = 0;

    // Reference model: architectural PC, a pending-discard marker, a 1-deep
    // queue of parked words, and the expected IF/ID contents.
    logic [31:0] m_pc;
    logic        m_drop;
    logic [31:0] m_drop_addr;
    logic [63:0] m_buf[$];
    logic [31:0] m_ifid_pc;
    logic [31:0] m_ifid_instr;
    logic        m_ifid_valid;
    logic [31:0] m_fetch_cnt;
    logic [31:0] m_bubble_cnt;

    // Memory model state.
    logic        mem_busy;
    logic [31:0] mem_addr;
    int          mem_lat;
    int          lat_min = 0;
    int          lat_max = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] wfun(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
    endfunction

    task automatic model_reset();
        m_pc         = RESET_PC;
        m_drop       = 1'b0;
        m_drop_addr  = '0;
        m_buf.delete();
        m_ifid_pc    = '0;
        m_ifid_instr = NOP_INSTR;
        m_ifid_valid = 1'b0;
        m_fetch_cnt  = '0;
        m_bubble_cnt = '0;
        mem_busy     = 1'b0;
        mem_lat      = 0;
    endtask

    task automatic check_reset_state();
        check("rst_req",   {31'd0, imem_req_o},   32'd0);
        check("rst_pc",    pc_IFID_o,             32'd0);
        check("rst_instr", instr_IFID_o,          NOP_INSTR);
        check("rst_valid", {31'd0, valid_IFID_o}, 32'd0);
        check("rst_fcnt",  fetch_cnt_o,           32'd0);
        check("rst_bcnt",  bubble_cnt_o,          32'd0);
    endtask

    // One clock cycle, entered and left at a falling edge.
    task automatic cycle(input logic fl, input logic st, input logic pw, input logic [31:0] tgt);
        logic        exp_req;
        logic [31:0] exp_addr;
        logic        done;
        logic [31:0] rd;
        #1;
        exp_req  = (m_buf.size() == 0);
        exp_addr = m_drop ? m_drop_addr : m_pc;
        check("valid", {31'd0, valid_IFID_o}, {31'd0, m_ifid_valid});
        check("instr", instr_IFID_o, m_ifid_instr);
        if (m_ifid_valid) check("ifid_pc", pc_IFID_o, m_ifid_pc);
        check("req", {31'd0, imem_req_o}, {31'd0, exp_req});
        if (exp_req) check("addr", imem_addr_o, exp_addr);
`ifdef FETCH_PERF_CNT_EN
        check("fetch_cnt",  fetch_cnt_o,  m_fetch_cnt);
        check("bubble_cnt", bubble_cnt_o, m_bubble_cnt);
`else
        check("fetch_cnt",  fetch_cnt_o,  32'd0);
        check("bubble_cnt", bubble_cnt_o, 32'd0);
`endif
        IFIDFlush_i     = fl;
        IFIDStall_i     = st;
        PCWrite_i       = pw;
        branch_target_i = tgt;
        // Memory responds to what the DUT actually asserts.
        if (imem_req_o) begin
            if (!mem_busy) begin
                mem_busy = 1'b1;
                mem_addr = imem_addr_o;
                mem_lat  = $urandom_range(lat_max, lat_min);
            end else begin
                check("addr_stable", imem_addr_o, mem_addr);
            end
            if (mem_lat == 0) begin
                imem_ack_i   = 1'b1;
                imem_rdata_i = wfun(mem_addr);
                mem_busy     = 1'b0;
            end else begin
                imem_ack_i   = 1'b0;
                imem_rdata_i = $urandom;
                mem_lat--;
            end
        end else begin
            imem_ack_i   = 1'($urandom_range(1, 0));
            imem_rdata_i = $urandom;
        end
        // Reference model step for the coming rising edge.
        done = imem_ack_i && exp_req;
        rd   = wfun(exp_addr);
        if (fl) begin
            m_ifid_valid = 1'b0;
            m_ifid_instr = NOP_INSTR;
            m_buf.delete();
            if (exp_req && !done) begin
                m_drop_addr = exp_addr;
                m_drop      = 1'b1;
            end else begin
                m_drop = 1'b0;
            end
            m_pc = tgt;
        end else if (st || !pw) begin
            if (done && m_drop) m_drop = 1'b0;
            else if (done) begin
                m_buf.push_back({m_pc, rd});
                m_pc = m_pc + 32'd4;
            end
        end else if (m_buf.size() != 0) begin
            {m_ifid_pc, m_ifid_instr} = m_buf.pop_front();
            m_ifid_valid = 1'b1;
            m_fetch_cnt  = m_fetch_cnt + 32'd1;
        end else if (done && !m_drop) begin
            m_ifid_pc    = m_pc;
            m_ifid_instr = rd;
            m_ifid_valid = 1'b1;
            m_pc         = m_pc + 32'd4;
            m_fetch_cnt  = m_fetch_cnt + 32'd1;
        end else begin
            if (done) m_drop = 1'b0;
            m_ifid_pc    = m_pc;
            m_ifid_instr = NOP_INSTR;
            m_ifid_valid = 1'b0;
            m_bubble_cnt = m_bubble_cnt + 32'd1;
        end
        @(negedge clk_i);
    endtask

    task automatic rcycle();
        logic        fl, st, pw;
        logic [31:0] tgt;
        int          sel;
        fl  = ($urandom_range(99, 0) < 8);
        st  = ($urandom_range(99, 0) < 20);
        pw  = ($urandom_range(99, 0) >= 10);
        sel = $urandom_range(15, 0);
        if (sel == 0)      tgt = 32'hFFFF_FFFC;
        else if (sel == 1) tgt = $urandom;
        else               tgt = $urandom & 32'h0000_FFFC;
        cycle(fl, st, pw, tgt);
    endtask

    task automatic apply_reset();
        rst_i      = 1'b0;
        imem_ack_i = 1'b0;
        model_reset();
        repeat (2) @(negedge clk_i);
        #1;
        check_reset_state();
        @(negedge clk_i);
        rst_i = 1'b1;
    endtask

    initial begin
        int guard;
        rst_i           = 1'b0;
        PCWrite_i       = 1'b1;
        IFIDStall_i     = 1'b0;
        IFIDFlush_i     = 1'b0;
        branch_target_i = '0;
        imem_ack_i      = 1'b0;
        imem_rdata_i    = '0;
        apply_reset();

        // Zero-wait memory: one instruction per cycle from RESET_PC.
        lat_min = 0; lat_max = 0;
        repeat (5) cycle(1'b0, 1'b0, 1'b1, 32'd0);

        // Two-cycle memory: bubbles alternate with instructions.
        lat_min = 1; lat_max = 1;
        repeat (8) cycle(1'b0, 1'b0, 1'b1, 32'd0);

        // Load-use stall while the ack arrives, then release.
        apply_reset();
        lat_min = 0; lat_max = 0;
        cycle(1'b0, 1'b0, 1'b1, 32'd0);
        cycle(1'b0, 1'b0, 1'b1, 32'd0);
        cycle(1'b0, 1'b1, 1'b0, 32'd0);
        repeat (4) cycle(1'b0, 1'b0, 1'b1, 32'd0);

        // Flush to 0x100 while the request for 0x20 waits three cycles.
        apply_reset();
        repeat (8) cycle(1'b0, 1'b0, 1'b1, 32'd0);
        lat_min = 3; lat_max = 3;
        cycle(1'b1, 1'b0, 1'b1, 32'h0000_0100);
        lat_min = 0; lat_max = 0;
        repeat (6) cycle(1'b0, 1'b0, 1'b1, 32'd0);

        // Flush and stall together: flush wins. Then wrap past the top of memory.
        cycle(1'b1, 1'b1, 1'b0, 32'hFFFF_FFF8);
        repeat (5) cycle(1'b0, 1'b0, 1'b1, 32'd0);

        // Random hazards against random memory latency.
        for (int ph = 0; ph < 4; ph++) begin
            lat_min = 0;
            lat_max = ph;
            repeat (600) rcycle();
        end

        // Reset in the middle of an outstanding request.
        lat_min = 2; lat_max = 3;
        guard = 0;
        while (!mem_busy && guard < 50) begin
            cycle(1'b0, 1'b0, 1'b1, 32'd0);
            guard++;
        end
        check("midrst_pending", {31'd0, mem_busy}, 32'd1);
        #1;
        check("midrst_req_before", {31'd0, imem_req_o}, 32'd1);
        #1;
        rst_i = 1'b0;
        #1;
        check("midrst_req_drop", {31'd0, imem_req_o}, 32'd0);
        apply_reset();
        lat_min = 0; lat_max = 2;
        repeat (300) rcycle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
